// File: rtl/jenkins_feeder.sv
// Buffers a message byte-by-byte, streams it to a Jenkins hasher and captures the result.
// Optional macro JENKINS_FEEDER_CHARSET_CHECK_EN drops non-alphanumeric bytes and flags err.
module jenkins_feeder #(
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        start,
    output logic        busy,
    output logic        sample,
    output logic [7:0]  value,
    input  logic        complete,
    input  logic [31:0] hash_in,
    output logic [31:0] hash,
    output logic        done,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic            sample_q, sample_d;
    logic [7:0]      value_q, value_d;
    logic [31:0]     hash_q, hash_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [7:0]      mem_q [DEPTH];

    logic            wr_accept;
    logic            byte_ok;
    logic            wr_store;
    logic [CW-1:0]   post_count;
    logic [7:0]      first_byte;

    function automatic logic is_alnum(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) ||
               ((b >= 8'h41) && (b <= 8'h5A)) ||
               ((b >= 8'h30) && (b <= 8'h39));
    endfunction

    assign wr_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
    assign busy     = (state_q == S_SEND) || (state_q == S_WAIT);
    assign sample   = sample_q;
    assign value    = value_q;
    assign hash     = hash_q;
    assign done     = done_q;
    assign err      = err_q;

    assign wr_accept = wr_en && wr_ready;
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
    assign byte_ok = is_alnum(wr_data);
`else
    assign byte_ok = 1'b1;
`endif
    assign wr_store   = wr_accept && byte_ok;
    assign post_count = count_q + CW'(wr_store);
    // A write landing in the same cycle as start on an empty buffer is the first byte.
    assign first_byte = (count_q == '0) ? wr_data : mem_q[0];

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned (no latch).
        state_d  = state_q;
        count_d  = count_q;
        ptr_d    = ptr_q;
        sample_d = 1'b0;
        value_d  = 8'h00;
        hash_d   = hash_q;
        done_d   = 1'b0;
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
        err_d    = err_q | (wr_accept && !byte_ok);
`else
        err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                count_d = post_count;
                if (start && (post_count != '0)) begin
                    state_d  = S_SEND;
                    ptr_d    = CW'(1);
                    sample_d = 1'b1;
                    value_d  = first_byte;
                end
            end
            S_SEND: begin
                if (ptr_q == count_q) begin
                    state_d = S_WAIT;
                end else begin
                    sample_d = 1'b1;
                    value_d  = mem_q[ptr_q[AW-1:0]];
                    ptr_d    = ptr_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (complete) begin
                    hash_d  = hash_in;
                    done_d  = 1'b1;
                    count_d = '0;
                    ptr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            ptr_q    <= '0;
            sample_q <= 1'b0;
            value_q  <= 8'h00;
            hash_q   <= 32'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ptr_q    <= ptr_d;
            sample_q <= sample_d;
            value_q  <= value_d;
            hash_q   <= hash_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the byte store is deliberately not reset; count gates every read of it.
    always_ff @(posedge clock) begin
        if (wr_store) begin
            mem_q[count_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_jenkins_feeder.sv
// Directed self-checking bench for jenkins_feeder at DEPTH=16.
// Expectations follow JENKINS_FEEDER_CHARSET_CHECK_EN when the bench is built with it.
module tb_jenkins_feeder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_ready;
    logic        start = 1'b0;
    logic        busy;
    logic        sample;
    logic [7:0]  value;
    logic        complete = 1'b0;
    logic [31:0] hash_in = 32'h0;
    logic [31:0] hash;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    int         cap_n;
    int         cap_first;
    bit         cap_gap;
    bit         cap_zero_bad;
    logic [7:0] cap_bytes [32];

    jenkins_feeder #(.DEPTH(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .start    (start),
        .busy     (busy),
        .sample   (sample),
        .value    (value),
        .complete (complete),
        .hash_in  (hash_in),
        .hash     (hash),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
        wr_data = 8'h00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Observes 24 cycles starting with the cycle right after the start edge.
    task automatic capture();
        int last;
        cap_n = 0;
        cap_first = -1;
        cap_gap = 1'b0;
        cap_zero_bad = 1'b0;
        last = -1;
        for (int c = 0; c < 24; c++) begin
            if (sample === 1'b1) begin
                if (cap_first < 0) cap_first = c;
                else if (last != c - 1) cap_gap = 1'b1;
                if (cap_n < 32) cap_bytes[cap_n] = value;
                cap_n++;
                last = c;
            end else if (value !== 8'h00) begin
                cap_zero_bad = 1'b1;
            end
            tick();
        end
    endtask

    task automatic finish_hash(input logic [31:0] h, input string tag);
        complete = 1'b1;
        hash_in  = h;
        tick();
        complete = 1'b0;
        hash_in  = 32'h0;
        total++;
        if (done !== 1'b1 || hash !== h || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_capture: done=%b hash=%h busy=%b, want done=1 hash=%h busy=0",
                     tag, done, hash, busy, h);
        end
        tick();
        total++;
        if (done !== 1'b0 || hash !== h) begin
            bad++;
            $display("FAIL %s_done_width: done=%b hash=%h, want done=0 hash=%h", tag, done, hash, h);
        end
    endtask

    task automatic check_stream(input string tag, input int n_exp, input logic [7:0] exp_bytes [32]);
        total++;
        if (cap_n !== n_exp || cap_first !== 0 || cap_gap !== 1'b0) begin
            bad++;
            $display("FAIL %s_shape: n=%0d first=%0d gap=%b, want n=%0d first=0 gap=0",
                     tag, cap_n, cap_first, cap_gap, n_exp);
        end
        total++;
        if (cap_zero_bad !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_value: nonzero value while sample=0, want 00", tag);
        end
        for (int i = 0; i < n_exp && i < cap_n; i++) begin
            total++;
            if (cap_bytes[i] !== exp_bytes[i]) begin
                bad++;
                $display("FAIL %s_byte%0d: got %h, want %h", tag, i, cap_bytes[i], exp_bytes[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || sample !== 1'b0 || value !== 8'h00 || done !== 1'b0 ||
            err !== 1'b0 || hash !== 32'h0 || wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: busy=%b sample=%b value=%h done=%b err=%b hash=%h wr_ready=%b, want 0 0 00 0 0 0 1",
                     busy, sample, value, done, err, hash, wr_ready);
        end
    endtask

    task automatic test_abc();
        logic [7:0] exp [32];
        exp[0] = 8'h61; exp[1] = 8'h62; exp[2] = 8'h63;
        write_byte(8'h61);
        write_byte(8'h62);
        write_byte(8'h63);
        pulse_start();
        capture();
        check_stream("abc", 3, exp);
        total++;
        if (busy !== 1'b1 || sample !== 1'b0) begin
            bad++;
            $display("FAIL abc_wait: busy=%b sample=%b, want busy=1 sample=0", busy, sample);
        end
        finish_hash(32'hDEADBEEF, "abc");
    endtask

    task automatic test_full();
        logic [7:0] exp [32];
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp[i] = 8'h41 + 8'(i);
            write_byte(8'h41 + 8'(i));
            if (i == 14) begin
                total++;
                if (wr_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL full_ready15: wr_ready=%b, want 1", wr_ready);
                end
            end
            if (i == 15) begin
                total++;
                if (wr_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL full_ready16: wr_ready=%b, want 0", wr_ready);
                end
            end
        end
        total++;
        if (wr_ready !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL full_overflow: wr_ready=%b err=%b, want 0 0", wr_ready, err);
        end
        pulse_start();
        capture();
        check_stream("full", 16, exp);
        finish_hash(32'h0BADF00D, "full");
    endtask

    task automatic test_empty_and_same_cycle();
        logic [7:0] exp [32];
        exp[0] = 8'h78;
        pulse_start();
        for (int c = 0; c < 4; c++) begin
            total++;
            if (busy !== 1'b0 || sample !== 1'b0) begin
                bad++;
                $display("FAIL empty_start_c%0d: busy=%b sample=%b, want 0 0", c, busy, sample);
            end
            tick();
        end
        wr_en   = 1'b1;
        wr_data = 8'h78;
        start   = 1'b1;
        tick();
        wr_en   = 1'b0;
        start   = 1'b0;
        capture();
        check_stream("same_cycle", 1, exp);
        finish_hash(32'h12345678, "same_cycle");
    endtask

    task automatic test_reset_mid_send();
        write_byte(8'h44);
        write_byte(8'h45);
        write_byte(8'h46);
        write_byte(8'h47);
        pulse_start();
        total++;
        if (sample !== 1'b1 || value !== 8'h44) begin
            bad++;
            $display("FAIL rst_send_first: sample=%b value=%h, want 1 44", sample, value);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (sample !== 1'b0 || value !== 8'h00 || wr_ready !== 1'b1 || busy !== 1'b0 || hash !== 32'h0) begin
            bad++;
            $display("FAIL rst_send_after: sample=%b value=%h wr_ready=%b busy=%b hash=%h, want 0 00 1 0 0",
                     sample, value, wr_ready, busy, hash);
        end
        complete = 1'b1;
        hash_in  = 32'h55AA55AA;
        tick();
        complete = 1'b0;
        hash_in  = 32'h0;
        total++;
        if (done !== 1'b0 || hash !== 32'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_send_complete: done=%b hash=%h busy=%b, want 0 0 0", done, hash, busy);
        end
        // Buffer must be empty after reset: a lone start does nothing.
        pulse_start();
        total++;
        if (busy !== 1'b0 || sample !== 1'b0) begin
            bad++;
            $display("FAIL rst_send_empty: busy=%b sample=%b, want 0 0", busy, sample);
        end
    endtask

    task automatic test_complete_during_send();
        logic [7:0] exp [32];
        exp[0] = 8'h31; exp[1] = 8'h32; exp[2] = 8'h33; exp[3] = 8'h34;
        write_byte(8'h31);
        write_byte(8'h32);
        write_byte(8'h33);
        write_byte(8'h34);
        complete = 1'b1;
        hash_in  = 32'hFEEDFACE;
        tick();
        complete = 1'b0;
        total++;
        if (done !== 1'b0 || hash !== 32'h0) begin
            bad++;
            $display("FAIL idle_complete: done=%b hash=%h, want 0 0", done, hash);
        end
        pulse_start();
        complete = 1'b1;
        hash_in  = 32'hCAFEF00D;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (done !== 1'b0 || hash !== 32'h0) begin
                bad++;
                $display("FAIL send_complete_c%0d: done=%b hash=%h, want 0 0", c, done, hash);
            end
        end
        complete = 1'b0;
        hash_in  = 32'h0;
        capture();
        total++;
        if (cap_n !== 2 || cap_bytes[0] !== 8'h33 || cap_bytes[1] !== 8'h34) begin
            bad++;
            $display("FAIL send_complete_tail: n=%0d b0=%h b1=%h, want 2 33 34",
                     cap_n, cap_bytes[0], cap_bytes[1]);
        end
        finish_hash(32'hA5A5A5A5, "send_complete");
    endtask

    task automatic test_charset();
        logic [7:0] exp [32];
        int         n_exp;
        logic       err_exp;
`ifdef JENKINS_FEEDER_CHARSET_CHECK_EN
        exp[0] = 8'h61; exp[1] = 8'h62;
        n_exp = 2;
        err_exp = 1'b1;
`else
        exp[0] = 8'h61; exp[1] = 8'h23; exp[2] = 8'h62;
        n_exp = 3;
        err_exp = 1'b0;
`endif
        write_byte(8'h61);
        write_byte(8'h23);
        write_byte(8'h62);
        total++;
        if (err !== err_exp) begin
            bad++;
            $display("FAIL charset_err: err=%b, want %b", err, err_exp);
        end
        pulse_start();
        capture();
        check_stream("charset", n_exp, exp);
        finish_hash(32'h0000ABCD, "charset");
        total++;
        if (err !== err_exp) begin
            bad++;
            $display("FAIL charset_sticky: err=%b, want %b", err, err_exp);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_full();
        test_empty_and_same_cycle();
        test_reset_mid_send();
        test_complete_during_send();
        test_charset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
